// File: rtl/qpsk_modulator.sv
`default_nettype none
// ============================================================================
// Module   : qpsk_modulator
// Function : Serial coded bits in, Gray-mapped QPSK I/Q symbols out, with a
//            per-block symbol counter and a last-symbol marker.
//            Build option QPSK_SKID_BUF_EN: 2-entry symbol FIFO and a
//            registered ready_out.
// Revision : 1.0 - initial release
// ============================================================================
module qpsk_modulator #(
  parameter int Ncbps = 192,
  parameter int WIDTH = 16,
  parameter int AMP   = 23170
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] I_out,
  output logic [WIDTH-1:0] Q_out,
  output logic             valid_out,
  output logic             last_out,
  input  logic             ready_in
);

  localparam int              c_nsym = Ncbps / 2;
  localparam int              c_cw   = (c_nsym > 1) ? $clog2(c_nsym) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(c_nsym - 1);
  localparam logic [WIDTH-1:0] c_pos = WIDTH'(AMP);
  localparam logic [WIDTH-1:0] c_neg = WIDTH'(-AMP);

  function automatic logic [WIDTH-1:0] f_map(input logic b);
    return b ? c_neg : c_pos;
  endfunction

  logic            r_phase;
  logic            r_b0;
  logic [c_cw-1:0] r_cnt;
  logic            w_bit_xfer;
  logic            w_sym_xfer;
  logic            w_push;

  assign w_bit_xfer = valid_in && ready_out;
  assign w_sym_xfer = valid_out && ready_in;
  assign w_push     = w_bit_xfer && r_phase;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_phase <= 1'b0;
      r_b0    <= 1'b0;
    end else if (w_bit_xfer) begin
      r_phase <= ~r_phase;
      if (!r_phase)
        r_b0 <= data_in;
    end
  end

  // Counts delivered symbols only, so input gaps never shift the block boundary
  always_ff @(posedge clk) begin
    if (!resetN)
      r_cnt <= '0;
    else if (w_sym_xfer)
      r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
  end

  assign last_out = valid_out && (r_cnt == c_last);

`ifdef QPSK_SKID_BUF_EN
  logic [WIDTH-1:0] r_fifo_i [0:1];
  logic [WIDTH-1:0] r_fifo_q [0:1];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;
  logic             r_ready;
  logic [1:0]       w_count_nxt;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_sym_xfer)
      w_count_nxt = r_count + 2'd1;
    else if (!w_push && w_sym_xfer)
      w_count_nxt = r_count - 2'd1;
  end

  // Ready is precomputed from the next occupancy, so a push next cycle always fits
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_fifo_i[0] <= '0;
      r_fifo_i[1] <= '0;
      r_fifo_q[0] <= '0;
      r_fifo_q[1] <= '0;
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_count     <= 2'd0;
      r_ready     <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo_i[r_wptr] <= f_map(r_b0);
        r_fifo_q[r_wptr] <= f_map(data_in);
        r_wptr           <= ~r_wptr;
      end
      if (w_sym_xfer)
        r_rptr <= ~r_rptr;
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != 2'd2);
    end
  end

  assign ready_out = r_ready;
  assign valid_out = (r_count != 2'd0);
  assign I_out     = r_fifo_i[r_rptr];
  assign Q_out     = r_fifo_q[r_rptr];
`else
  logic             r_valid;
  logic [WIDTH-1:0] r_i;
  logic [WIDTH-1:0] r_q;

  assign ready_out = resetN && (!r_valid || ready_in);

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_valid <= 1'b0;
      r_i     <= '0;
      r_q     <= '0;
    end else if (w_push) begin
      r_valid <= 1'b1;
      r_i     <= f_map(r_b0);
      r_q     <= f_map(data_in);
    end else if (w_sym_xfer) begin
      r_valid <= 1'b0;
    end
  end

  assign valid_out = r_valid;
  assign I_out     = r_i;
  assign Q_out     = r_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_qpsk_modulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_qpsk_modulator
// Function : Directed and random-gap checks of qpsk_modulator against
//            hand-computed symbols and a handshake-level scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qpsk_modulator;

  localparam logic [15:0] c_pos  = 16'd23170;
  localparam logic [15:0] c_neg  = 16'd42366;   // -23170 in 16-bit two's complement
  localparam int          c_nsym = 96;

  logic        clk      = 1'b0;
  logic        resetN   = 1'b0;
  logic        data_in  = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_in = 1'b0;
  logic        ready_out;
  logic        valid_out;
  logic        last_out;
  logic [15:0] I_out;
  logic [15:0] Q_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  qpsk_modulator #(.Ncbps(192), .WIDTH(16), .AMP(23170)) u_dut (
    .clk      (clk),
    .resetN   (resetN),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .I_out    (I_out),
    .Q_out    (Q_out),
    .valid_out(valid_out),
    .last_out (last_out),
    .ready_in (ready_in)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    int   guard;
    logic acc;
    guard    = 0;
    data_in  = b;
    valid_in = 1'b1;
    do begin
      @(negedge clk);
      acc = ready_out;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) check("bit_timeout", {31'd0, acc}, 32'd1);
  endtask

  // Scoreboard: symbols built from accepted bits, compared in order on delivery
  logic [31:0] q_exp[$];
  logic        m_phase = 1'b0;
  logic        m_b0    = 1'b0;
  logic        m_pend  = 1'b0;
  logic        m_stall = 1'b0;
  int          m_cnt   = 0;
  int          n_pop   = 0;
  int          n_last  = 0;
  logic [15:0] s_i, s_q;
  logic        s_last;
  logic [31:0] e;

  initial forever begin
    @(negedge clk);
    if (!resetN) begin
      check("rst_ready", {31'd0, ready_out}, 32'd0);
      check("rst_valid", {31'd0, valid_out}, 32'd0);
      q_exp.delete();
      m_phase = 1'b0;
      m_pend  = 1'b0;
      m_stall = 1'b0;
      m_cnt   = 0;
    end else begin
      if (m_pend) check("latency", {31'd0, valid_out}, 32'd1);
      if (m_stall) begin
        check("hold_valid", {31'd0, valid_out}, 32'd1);
        check("hold_i", {16'd0, I_out}, {16'd0, s_i});
        check("hold_q", {16'd0, Q_out}, {16'd0, s_q});
        check("hold_last", {31'd0, last_out}, {31'd0, s_last});
      end
      if (valid_out && ready_in) begin
        if (q_exp.size() == 0) begin
          check("sb_extra", {31'd0, valid_out}, 32'd0);
        end else begin
          e = q_exp.pop_front();
          check("sym_i", {16'd0, I_out}, {16'd0, e[31:16]});
          check("sym_q", {16'd0, Q_out}, {16'd0, e[15:0]});
          check("sym_last", {31'd0, last_out}, {31'd0, (m_cnt == c_nsym - 1)});
          m_cnt = (m_cnt == c_nsym - 1) ? 0 : m_cnt + 1;
          n_pop++;
          if (last_out) n_last++;
        end
      end else if (!valid_out) begin
        check("last_idle", {31'd0, last_out}, 32'd0);
      end
      m_pend = 1'b0;
      if (valid_in && ready_out) begin
        if (!m_phase) begin
          m_b0 = data_in;
        end else begin
          q_exp.push_back({m_b0 ? c_neg : c_pos, data_in ? c_neg : c_pos});
          m_pend = 1'b1;
        end
        m_phase = ~m_phase;
      end
      m_stall = valid_out && !ready_in;
      s_i     = I_out;
      s_q     = Q_out;
      s_last  = last_out;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic        bits31 [8];
  logic [31:0] exp31  [4];
  int          p0, l0;
  logic        done;

  initial begin
    bits31 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    exp31  = '{{c_pos, c_pos}, {c_neg, c_neg}, {c_pos, c_neg}, {c_neg, c_pos}};

    resetN   = 1'b0;
    ready_in = 1'b1;
    step();
    step();
    check("rst_i", {16'd0, I_out}, 32'd0);
    check("rst_q", {16'd0, Q_out}, 32'd0);
    check("rst_lastout", {31'd0, last_out}, 32'd0);
    resetN = 1'b1;

    // Four reference symbols, each visible one cycle after its Q bit
    for (int k = 0; k < 4; k++) begin
      drive_bit(bits31[2*k]);
      check("gap_valid", {31'd0, valid_out}, 32'd0);
      drive_bit(bits31[2*k+1]);
      check("ref_valid", {31'd0, valid_out}, 32'd1);
      check("ref_i", {16'd0, I_out}, {16'd0, exp31[k][31:16]});
      check("ref_q", {16'd0, Q_out}, {16'd0, exp31[k][15:0]});
      check("ref_last", {31'd0, last_out}, 32'd0);
    end
    valid_in = 1'b0;
    step();

    // Reset after a lone b0 discards it
    drive_bit(1'b1);
    valid_in = 1'b0;
    resetN   = 1'b0;
    step();
    check("midrst_ready", {31'd0, ready_out}, 32'd0);
    check("midrst_valid", {31'd0, valid_out}, 32'd0);
    resetN = 1'b1;
    drive_bit(1'b0);
    check("midrst_nosym", {31'd0, valid_out}, 32'd0);
    drive_bit(1'b1);
    check("midrst_valid2", {31'd0, valid_out}, 32'd1);
    check("midrst_i", {16'd0, I_out}, {16'd0, c_pos});
    check("midrst_q", {16'd0, Q_out}, {16'd0, c_neg});
    check("midrst_last", {31'd0, last_out}, 32'd0);
    valid_in = 1'b0;
    step();

    // Downstream stall with a symbol pending, then two more bits behind it
    ready_in = 1'b0;
    drive_bit(1'b0);
    drive_bit(1'b1);
    check("stall_valid", {31'd0, valid_out}, 32'd1);
    p0 = n_pop;
    fork
      begin
        drive_bit(1'b1);
        drive_bit(1'b0);
        valid_in = 1'b0;
      end
      begin
        repeat (5) begin
          @(negedge clk);
          check("stall_v", {31'd0, valid_out}, 32'd1);
          check("stall_i", {16'd0, I_out}, {16'd0, c_pos});
          check("stall_q", {16'd0, Q_out}, {16'd0, c_neg});
        end
        @(posedge clk);
        #1;
        ready_in = 1'b1;
      end
    join
    repeat (5) step();
    check("stall_pops", 32'(n_pop - p0), 32'd2);

    // One full block at full rate
    resetN = 1'b0;
    step();
    resetN   = 1'b1;
    ready_in = 1'b1;
    p0 = n_pop;
    l0 = n_last;
    for (int i = 0; i < 192; i++) drive_bit(1'($urandom_range(0, 1)));
    valid_in = 1'b0;
    repeat (4) step();
    check("blk_pops", 32'(n_pop - p0), 32'd96);
    check("blk_lasts", 32'(n_last - l0), 32'd1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    check("nextblk_valid", {31'd0, valid_out}, 32'd1);
    check("nextblk_last", {31'd0, last_out}, 32'd0);
    valid_in = 1'b0;
    step();

    // Ten blocks with random input gaps and random downstream backpressure
    resetN = 1'b0;
    step();
    resetN = 1'b1;
    p0   = n_pop;
    l0   = n_last;
    done = 1'b0;
    fork
      begin
        while (!done) begin
          step();
          ready_in = 1'($urandom_range(0, 1));
        end
      end
      begin
        for (int i = 0; i < 1920; i++) begin
          valid_in = 1'b0;
          repeat ($urandom_range(0, 1)) step();
          drive_bit(1'($urandom_range(0, 1)));
        end
        valid_in = 1'b0;
        done     = 1'b1;
      end
    join
    ready_in = 1'b1;
    repeat (6) step();
    check("rand_pops", 32'(n_pop - p0), 32'd960);
    check("rand_lasts", 32'(n_last - l0), 32'd10);
    check("rand_drained", 32'(q_exp.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qpsk_modulator.md
QPSK_MODULATOR -- requirements
Module: qpsk_modulator

Interface
REQ-001 Parameter Ncbps, default 192, coded bits per block; SHALL be even.
REQ-002 Parameter WIDTH, default 16, I/Q sample width, signed two's complement.
REQ-003 Parameter AMP, default 23170, QPSK amplitude, 1/sqrt(2) in Q1.15.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 resetN  input  1  reset; synchronous and active-low, sampled on rising clk edge.
REQ-006 data_in  input  1  serial interleaved coded bit.
REQ-007 valid_in  input  1  data_in valid.
REQ-008 ready_out  output  1  block can accept a bit this cycle.
REQ-009 I_out  output  WIDTH  in-phase sample.
REQ-010 Q_out  output  WIDTH  quadrature sample.
REQ-011 valid_out  output  1  I_out/Q_out/last_out valid.
REQ-012 last_out  output  1  marks the final symbol, Ncbps/2, of a block.
REQ-013 ready_in  input  1  downstream accepts the symbol this cycle.

Function
REQ-014 Bit transfer SHALL occur when valid_in && ready_out; symbol transfer SHALL occur when valid_out && ready_in.
REQ-015 Phase register: 0 = expecting I bit, 1 = expecting Q bit; SHALL toggle on every bit transfer.
REQ-016 Bit transferred in phase 0 SHALL be stored as b0; bit transferred in phase 1 is b1 and completes a symbol.
REQ-017 Mapping: b=0 -> +AMP, b=1 -> -AMP; I from b0, Q from b1.
REQ-018 Latency: valid_out SHALL assert on the cycle after the b1 transfer, with I_out/Q_out already mapped.
REQ-019 While valid_out && !ready_in, I_out, Q_out, valid_out and last_out SHALL hold stable.
REQ-020 valid_out SHALL deassert after a symbol transfer unless a new symbol completes in the same cycle.
REQ-021 Symbol counter runs 0..Ncbps/2-1, increments on each symbol transfer, and wraps to 0 after Ncbps/2-1.
REQ-022 last_out SHALL equal 1 only while valid_out and the counter is Ncbps/2-1.
REQ-023 A simultaneous symbol transfer and new symbol completion SHALL load the new symbol with no bubble.
REQ-024 valid_in low between the b0 and b1 transfers SHALL keep b0 and phase=1 indefinitely.
REQ-025 The counter SHALL count symbols only and SHALL be unaffected by valid_in gaps.

Reset
REQ-026 On resetN=0 at a clk edge: valid_out=0, last_out=0, I_out=0, Q_out=0, phase=0, counter=0, and any buffered symbols are dropped.
REQ-027 Reset mid-pair or mid-block SHALL discard the partial pair; the first bit after reset is b0 of symbol 0.
REQ-028 ready_out SHALL be 0 while resetN=0.

Configuration
REQ-029 Macro QPSK_SKID_BUF_EN not defined:
  - ready_out = !valid_out || ready_in, combinational from ready_in.
  - a single output register holds one symbol.
REQ-030 Macro QPSK_SKID_BUF_EN defined:
  - a 2-entry symbol FIFO sits in front of the outputs.
  - ready_out SHALL be registered, with no combinational path from ready_in.
  - ready_out SHALL be 1 iff the FIFO holds fewer than 2 entries, or holds exactly 1 entry with phase=0.
  - output ordering and REQ-018..REQ-025 SHALL hold unchanged.
  - no symbol SHALL be lost or duplicated under any ready_in pattern.

Verification
REQ-031 Reset, then bits 0,0,1,1,0,1,1,0 with valid_in=1 and ready_in=1 -> symbols (+23170,+23170), (-23170,-23170), (+23170,-23170), (-23170,+23170), each one cycle after its Q bit.
REQ-032 192 bits streamed with ready_in=1 -> exactly 96 valid_out pulses, last_out only on the 96th; next block symbol 0 has last_out=0.
REQ-033 ready_in=0 for 5 cycles with a symbol pending -> outputs stable for 5 cycles, upstream bits 2,3 not lost, order preserved after release.
REQ-034 resetN=0 for 1 cycle after b0=1 is transferred, then bits 0,1 -> single symbol (+23170,-23170) with counter at 0.
REQ-035 Random valid_in and ready_in (50%) over 10 blocks, run with and without QPSK_SKID_BUF_EN -> output sequence matches the reference model and last_out falls every 96 symbols.
